// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with ACK check
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   tx_data, tx_valid     command byte and send request
//   tx_ready              high in IDLE; byte accepted on tx_valid && tx_ready
//   busy                  high from acceptance until back in IDLE
//   done, error           one-cycle end-of-transfer pulse; error = NACK or timeout
//   ps2_clk_in/data_in    raw open-drain line levels
//   ps2_clk_oe/data_oe    1 pulls the corresponding line low

`timescale 1ns/1ps

// Two-flop synchronizer followed by a run-length glitch filter: the output
// only follows the input after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);

    logic          meta;
    logic          sync;
    logic [FW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + FW'(1);
            end
        end
    end
endmodule

module ps2_host_tx #(
    parameter int CLK_FREQ         = 33333333,
    parameter int INHIBIT_US       = 120,
    parameter int START_TIMEOUT_US = 15000,
    parameter int XFER_TIMEOUT_US  = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    // Cycle counts are computed in 64 bits: us * Hz overflows 32 bits at
    // realistic clock rates.
    localparam longint INHIBIT_CYC = (longint'(INHIBIT_US) * longint'(CLK_FREQ)) / 64'sd1000000;
    localparam longint START_CYC   = (longint'(START_TIMEOUT_US) * longint'(CLK_FREQ)) / 64'sd1000000;
    localparam longint XFER_CYC    = (longint'(XFER_TIMEOUT_US) * longint'(CLK_FREQ)) / 64'sd1000000;
    localparam longint MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam longint MAX_CYC     = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
    localparam int     TW          = $clog2(MAX_CYC + 1);

    // Counters load N-1 so that a state lasts exactly N cycles before the
    // zero test fires.
    localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] START_LOAD   = TW'(START_CYC - 1);
    localparam logic [TW-1:0] XFER_LOAD    = TW'(XFER_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic          parity;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmr;

    logic clk_f;
    logic data_f;
    logic clk_f_d;
    logic fall;
    logic active;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_f)
    );

    assign fall   = clk_f_d & ~clk_f;
    // States in which the device owns the clock and the watchdog runs.
    assign active = (state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
                    (state == S_STOP)  || (state == S_WAIT_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= '0;
            parity      <= 1'b0;
            bit_cnt     <= '0;
            tmr         <= '0;
            clk_f_d     <= 1'b1;
        end else begin
            clk_f_d <= clk_f;
            done    <= 1'b0;

            if (active && (tmr == '0)) begin
                // Watchdog expiry beats a simultaneous falling edge.
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                error       <= 1'b1;
                done        <= 1'b1;
                state       <= S_DONE;
            end else begin
                if (active) begin
                    tmr <= tmr - TW'(1);
                end

                case (state)
                    S_IDLE: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_valid) begin
                            shreg      <= tx_data;
                            parity     <= ~^tx_data;
                            error      <= 1'b0;
                            bit_cnt    <= '0;
                            tmr        <= INHIBIT_LOAD;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= S_INHIBIT;
                        end
                    end

                    S_INHIBIT: begin
                        if (tmr == '0) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            tmr         <= START_LOAD;
                            state       <= S_START;
                        end else begin
                            tmr <= tmr - TW'(1);
                            // Pull data low one cycle before the clock is
                            // released so the device sees a valid request.
                            if (tmr == TW'(1)) begin
                                ps2_data_oe <= 1'b1;
                            end
                        end
                    end

                    S_START: begin
                        if (fall) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b0, shreg[7:1]};
                            bit_cnt     <= 4'd1;
                            tmr         <= XFER_LOAD;
                            state       <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (fall) begin
                            if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~parity;
                                state       <= S_PARITY;
                            end else begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b0, shreg[7:1]};
                                bit_cnt     <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_PARITY: begin
                        if (fall) begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_STOP;
                        end
                    end

                    S_STOP: begin
                        if (fall) begin
                            // Device holds data low for ACK; high means NACK.
                            error <= data_f;
                            state <= S_WAIT_IDLE;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (clk_f && data_f) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model

`timescale 1ns/1ps

module tb_ps2_host_tx;
    localparam int CLK_FREQ         = 1000000;
    localparam int INHIBIT_US       = 120;
    localparam int START_TIMEOUT_US = 500;
    localparam int XFER_TIMEOUT_US  = 2000;
    localparam int FILTER_LEN       = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    ps2_host_tx #(
        .CLK_FREQ         (CLK_FREQ),
        .INHIBIT_US       (INHIBIT_US),
        .START_TIMEOUT_US (START_TIMEOUT_US),
        .XFER_TIMEOUT_US  (XFER_TIMEOUT_US),
        .FILTER_LEN       (FILTER_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic request(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_idle", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("clk_oe_after_accept", ps2_clk_oe, 1);
        check("busy_after_accept", busy, 1);
        check("tx_ready_after_accept", tx_ready, 0);
    endtask

    task automatic inhibit_phase();
        int   n;
        logic first_data;
        logic last_data;
        n          = 0;
        first_data = ps2_data_oe;
        last_data  = 1'b0;
        while (ps2_clk_oe && n < 1000) begin
            last_data = ps2_data_oe;
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INHIBIT_US);
        check("data_oe_early", first_data, 0);
        check("data_low_before_release", last_data, 1);
        check("start_bit_driven", ps2_data_oe, 1);
    endtask

    // Device clocking at 80 cycles per bit; data sampled just before each
    // rising edge. With ack, data is pulled low during the 10th high phase.
    task automatic device(input int nclk, input bit ack, input bit glitch, output logic [9:0] bits);
        bits = '0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            dev_clk = 1'b0;
            if (glitch) begin
                repeat (20) @(negedge clk);
                dev_clk = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk = 1'b0;
                repeat (18) @(negedge clk);
            end else begin
                repeat (40) @(negedge clk);
            end
            if (i < 10) bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i < 10) begin
                repeat (10) @(negedge clk);
                if (i == 9 && ack) dev_data = 1'b0;
                if (glitch) begin
                    repeat (15) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (2) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (13) @(negedge clk);
                end else begin
                    repeat (30) @(negedge clk);
                end
            end else begin
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("tx_ready_back", tx_ready, 1);
        check("busy_clear", busy, 0);
        check("clk_oe_released", ps2_clk_oe, 0);
        check("data_oe_released", ps2_data_oe, 0);
    endtask

    task automatic full_send(input logic [7:0] b, input logic [9:0] exp_bits, input bit ack,
                             input bit glitch, input logic exp_err);
        logic [9:0] bits;
        int         n;
        int         d0;
        d0 = done_cnt;
        request(b);
        inhibit_phase();
        device(11, ack, glitch, bits);
        check("frame_bits", bits, exp_bits);
        wait_done(500, n);
        check("error_flag", error, exp_err);
        after_done();
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        logic [9:0] bits;
        int         n;
        int         d0;

        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED with ACK: LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1
        full_send(8'hED, 10'h3ED, 1'b1, 1'b0, 1'b0);

        // 0xF4 with ACK while a second request is held during the transfer
        d0 = done_cnt;
        request(8'hF4);
        inhibit_phase();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        check("ready_low_busy", tx_ready, 0);
        device(11, 1'b1, 1'b0, bits);
        tx_valid = 1'b0;
        check("frame_bits_f4", bits, 10'h2F4);
        wait_done(500, n);
        check("error_f4", error, 0);
        after_done();
        repeat (20) @(negedge clk);
        check("no_queued_send", ps2_clk_oe, 0);
        check("done_pulses_f4", done_cnt - d0, 1);

        // 0xFF NACKed by the device
        full_send(8'hFF, 10'h3FF, 1'b0, 1'b0, 1'b1);

        // Device never clocks: start timeout
        request(8'hA5);
        inhibit_phase();
        wait_done(1000, n);
        check_range("start_timeout_len", n, 495, 505);
        check("start_timeout_err", error, 1);
        after_done();

        // Device stops after four clocks: transfer timeout, then retry
        request(8'hF4);
        inhibit_phase();
        device(4, 1'b1, 1'b0, bits);
        wait_done(3000, n);
        check_range("xfer_timeout_len", n, 1680, 1700);
        check("xfer_timeout_err", error, 1);
        after_done();
        full_send(8'hF4, 10'h2F4, 1'b1, 1'b0, 1'b0);

        // Two-cycle clock glitches in every phase
        full_send(8'hED, 10'h3ED, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset while in DATA
        request(8'h00);
        inhibit_phase();
        device(3, 1'b1, 1'b0, bits);
        check("data_bit_low", ps2_data_oe, 1);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        check("rst_mid_data_oe", ps2_data_oe, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        full_send(8'hED, 10'h3ED, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the send side of the PS/2 link whose receive side is the keyboard-to-ASCII decoder.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) and reports the device ACK.
- Drives the open-drain PS/2 clock and data lines through low-only output enables.
- Sits beside the keyboard receiver. `busy` lets the top level mask the receiver during a transmit.

Parameters:
- CLK_FREQ, 33333333, system clock frequency in Hz.
- INHIBIT_US, 120, time the clock line is held low before the start bit, in µs.
- START_TIMEOUT_US, 15000, maximum time from clock release to the first device falling edge.
- XFER_TIMEOUT_US, 2000, maximum time from the first falling edge to the ACK sample.
- FILTER_LEN, 8, number of consecutive equal synchronized samples needed to accept a new line level.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send `tx_data`.
- tx_ready  out  1  high in IDLE; a byte is accepted on a cycle where `tx_valid && tx_ready`.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse at the end of every transfer, successful or not.
- error  out  1  valid with `done`: 1 on NACK or timeout; held until the next acceptance.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 pulls the clock line low, 0 releases it.
- ps2_data_oe  out  1  1 pulls the data line low, 0 releases it.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; `tx_ready`=1; `busy`=0; `done`=0; `error`=0; `ps2_clk_oe`=0; `ps2_data_oe`=0.
  - Filters preset to 1; all counters cleared.
  - Reset mid-transfer releases both lines immediately and does not pulse `done`.
- Input conditioning:
  - Each line passes a 2-FF synchronizer, then a glitch filter that changes its output only after FILTER_LEN equal consecutive samples.
  - `fall` = one-cycle pulse on a filtered clock 1->0 transition.
- On acceptance:
  - Latch `tx_data` into a shift register.
  - Parity = ~^`tx_data` (odd parity).
  - Clear `error`; set `bit_cnt`=0; go to INHIBIT.
- States:
  - IDLE: both OEs 0.
  - INHIBIT: `ps2_clk_oe`=1 for INHIBIT_US*CLK_FREQ/1e6 cycles. `ps2_data_oe` is set to 1 on the last cycle, so data is low before clock release. Then go to START.
  - START: `ps2_clk_oe`=0, `ps2_data_oe`=1 (start bit). Load the timeout counter with START_TIMEOUT. On `fall`: drive bit0, load the timeout counter with XFER_TIMEOUT, go to DATA.
  - DATA: on each `fall`, drive the next bit LSB-first (`ps2_data_oe`=~bit). After the falling edge that drove bit7, the next `fall` drives parity and goes to PARITY.
  - PARITY: on `fall`, `ps2_data_oe`=0 (stop bit, line released), go to STOP.
  - STOP: on `fall`, sample filtered data. 0 = ACK (`error` stays 0); 1 = NACK (`error`=1). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and data=1, then go to DONE.
    - A timeout here also ends the transfer: `error`=1, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Timeout: in START through WAIT_IDLE, if the counter reaches 0, release both lines, set `error`=1, go to DONE.
  - If timeout and `fall` occur in the same cycle, the timeout wins.
- Request handling:
  - `tx_valid` while not in IDLE is ignored; the byte is not queued.
  - Latency: acceptance-cycle+1 `ps2_clk_oe` rises; DONE→IDLE next cycle; `tx_ready` reasserts the cycle after `done`.
- Data is changed only within FILTER_LEN+3 cycles after the physical falling edge, well inside the ≥15 µs clock-low phase.
- Counter widths are derived with `$clog2` of the largest cycle count.

Test Plan:
- Send 0xED, with the BFM device clocking at 12.5 kHz and ACKing:
  - `ps2_clk_oe` low ≥4000 cycles at 33.3 MHz, then data low before clock release.
  - Bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` pulses once with `error`=0.
- Send 0xF4 with ACK → bits 0,0,1,0,1,1,1,1, parity 0; `error`=0.
- Device NACKs 0xFF (data high at the 11th falling edge) → `done` with `error`=1; both OEs 0 afterwards.
- Device never clocks → after START_TIMEOUT (shortened via parameters in the bench) `done` with `error`=1, both OEs 0, `tx_ready` back to 1.
- Device stops after 4 clocks → XFER timeout, `error`=1; a retry of 0xF4 then completes with `error`=0.
- Two-cycle glitches on `ps2_clk_in` with FILTER_LEN=8 → no extra bit shifts, correct byte sent.
- `tx_valid` asserted during a transfer → ignored.
- Async reset asserted in DATA → both OEs 0 within the same cycle, no `done` pulse; the next send works.
